// File: rtl/adau_pkg.sv
// Shared constants for the ADAU1761 SPI control-port responder.
// Chip address, register window base, frame FSM encoding.
package adau_pkg;

   localparam logic [6:0]  ADAU_CHIP_ADDR        = 7'h00;
   localparam logic [15:0] ADAU_REG_BASE         = 16'h4000;
   localparam int          ADAU_SPI_DUMMY_FRAMES = 3;

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_CHIP    = 3'd1;
   localparam logic [2:0] ST_ADDR_HI = 3'd2;
   localparam logic [2:0] ST_ADDR_LO = 3'd3;
   localparam logic [2:0] ST_DATA    = 3'd4;
   localparam logic [2:0] ST_SKIP    = 3'd5;

endpackage

// File: rtl/spi_input_sync.sv
// Two-flop synchronizers for the SPI pins plus edge pulses
// on the synchronized sclk and cs_n.
module spi_input_sync (
   input  logic clk,
   input  logic reset,
   input  logic i_sclk,
   input  logic i_cs_n,
   input  logic i_mosi,
   output logic o_mosi,
   output logic o_sclk_rise,
   output logic o_sclk_fall,
   output logic o_cs_fall,
   output logic o_cs_rise
);

   logic [2:0] r_sclk;
   logic [2:0] r_cs;
   logic [1:0] r_mosi;

   // shift pins through two sync stages and one history stage
   always_ff @(posedge clk) begin
      if (reset) begin
         r_sclk <= 3'b000;
         r_cs   <= 3'b111;
         r_mosi <= 2'b00;
      end else begin
         r_sclk <= {r_sclk[1:0], i_sclk};
         r_cs   <= {r_cs[1:0], i_cs_n};
         r_mosi <= {r_mosi[0], i_mosi};
      end
   end

   assign o_mosi      = r_mosi[1];
   assign o_sclk_rise = r_sclk[1] & ~r_sclk[2];
   assign o_sclk_fall = ~r_sclk[1] & r_sclk[2];
   assign o_cs_fall   = ~r_cs[1] & r_cs[2];
   assign o_cs_rise   = r_cs[1] & ~r_cs[2];

endmodule

// File: rtl/adau_spi_responder.sv
// SPI slave modelling the ADAU1761 control port: decodes
// chip/addr/data bytes, holds a register window, answers reads.
module adau_spi_responder
   import adau_pkg::*;
#(
   parameter logic [6:0]  CHIP_ADDR = ADAU_CHIP_ADDR,
   parameter logic [15:0] BASE_ADDR = ADAU_REG_BASE,
   parameter int          REG_COUNT = 256
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        sclk,
   input  logic        cs_n,
   input  logic        mosi,
   output logic        miso,
   output logic        miso_oe,
   output logic        spi_enabled,
   output logic        wr_valid,
   output logic [15:0] wr_addr,
   output logic [7:0]  wr_data,
   output logic        core_clk_en
);

   localparam int IW = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;

   logic w_mosi, w_sclk_rise, w_sclk_fall, w_cs_fall, w_cs_rise;

   spi_input_sync u_sync (
      .clk         (clk),
      .reset       (reset),
      .i_sclk      (sclk),
      .i_cs_n      (cs_n),
      .i_mosi      (mosi),
      .o_mosi      (w_mosi),
      .o_sclk_rise (w_sclk_rise),
      .o_sclk_fall (w_sclk_fall),
      .o_cs_fall   (w_cs_fall),
      .o_cs_rise   (w_cs_rise)
   );

   logic [2:0]  r_state;
   logic [2:0]  r_bitcnt;
   logic [6:0]  r_shift;
   logic        r_rw;
   logic [7:0]  r_addr_hi;
   logic [15:0] r_ptr;
   logic [7:0]  r_oshift;
   logic        r_oload;
   logic [1:0]  r_dummy;
   logic        r_spi_en;
   logic        r_wr_valid;
   logic [15:0] r_wr_addr;
   logic [7:0]  r_wr_data;
   logic        r_cke;
   logic [7:0]  r_regs [REG_COUNT];

   logic [7:0]  w_byte;
   logic        w_active;
   logic        w_done;
   logic [15:0] w_wr_off;
   logic        w_wr_in;
   logic        w_reg_we;
   logic [15:0] w_rd_addr;
   logic [15:0] w_rd_off;
   logic        w_rd_in;
   logic [7:0]  w_rd_data;

   assign w_byte   = {r_shift, w_mosi};
   assign w_active = (r_state == ST_CHIP) || (r_state == ST_ADDR_HI) ||
                     (r_state == ST_ADDR_LO) || (r_state == ST_DATA);
   assign w_done   = w_active && w_sclk_rise && (r_bitcnt == 3'd7);

   assign w_wr_off = r_ptr - BASE_ADDR;
   assign w_wr_in  = ({16'd0, w_wr_off} < 32'(REG_COUNT));
   assign w_reg_we = w_done && (r_state == ST_DATA) && !r_rw && w_wr_in;

   assign w_rd_addr = (r_state == ST_ADDR_LO) ? {r_addr_hi, w_byte}
                                              : r_ptr + 16'd1;
   assign w_rd_off  = w_rd_addr - BASE_ADDR;
   assign w_rd_in   = ({16'd0, w_rd_off} < 32'(REG_COUNT));
   assign w_rd_data = w_rd_in ? r_regs[w_rd_off[IW-1:0]] : 8'h00;

   // count cs_n rising edges until SPI mode latches
   always_ff @(posedge clk) begin
      if (reset) begin
         r_dummy  <= 2'd0;
         r_spi_en <= 1'b0;
      end else if (!r_spi_en && w_cs_rise) begin
         if (r_dummy == 2'(ADAU_SPI_DUMMY_FRAMES - 1))
            r_spi_en <= 1'b1;
         r_dummy <= r_dummy + 2'd1;
      end
   end

   // register window storage, written by completed data bytes
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < REG_COUNT; i++)
            r_regs[i] <= 8'h00;
      end else if (w_reg_we) begin
         r_regs[w_wr_off[IW-1:0]] <= w_byte;
      end
   end

   // frame FSM: byte assembly, decode, strobe and read shifter
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= ST_IDLE;
         r_bitcnt   <= 3'd0;
         r_shift    <= 7'd0;
         r_rw       <= 1'b0;
         r_addr_hi  <= 8'h00;
         r_ptr      <= 16'h0000;
         r_oshift   <= 8'h00;
         r_oload    <= 1'b0;
         r_wr_valid <= 1'b0;
         r_wr_addr  <= 16'h0000;
         r_wr_data  <= 8'h00;
         r_cke      <= 1'b0;
      end else begin
         r_wr_valid <= 1'b0;
         r_cke      <= r_regs[0][0];
         if (w_active && w_sclk_rise) begin
            r_shift  <= w_byte[6:0];
            r_bitcnt <= r_bitcnt + 3'd1;
         end
         if (w_done) begin
            case (r_state)
               ST_CHIP: begin
                  if (w_byte[7:1] != CHIP_ADDR) begin
                     r_state <= ST_SKIP;
                  end else begin
                     r_rw    <= w_byte[0];
                     r_state <= ST_ADDR_HI;
                  end
               end
               ST_ADDR_HI: begin
                  r_addr_hi <= w_byte;
                  r_state   <= ST_ADDR_LO;
               end
               ST_ADDR_LO: begin
                  r_ptr   <= {r_addr_hi, w_byte};
                  r_state <= ST_DATA;
                  if (r_rw) begin
                     r_oshift <= w_rd_data;
                     r_oload  <= 1'b1;
                  end
               end
               ST_DATA: begin
                  r_ptr <= r_ptr + 16'd1;
                  if (r_rw) begin
                     r_oshift <= w_rd_data;
                     r_oload  <= 1'b1;
                  end else begin
                     r_wr_valid <= 1'b1;
                     r_wr_addr  <= r_ptr;
                     r_wr_data  <= w_byte;
                  end
               end
               default: ;
            endcase
         end else if (w_sclk_fall && (r_state == ST_DATA) && r_rw) begin
            // the first fall after a load presents bit 7, so it must not shift
            if (r_oload)
               r_oload <= 1'b0;
            else
               r_oshift <= {r_oshift[6:0], 1'b0};
         end
         if ((r_state == ST_IDLE) && w_cs_fall && r_spi_en) begin
            r_state  <= ST_CHIP;
            r_bitcnt <= 3'd0;
            r_oload  <= 1'b0;
         end
         if (w_cs_rise)
            r_state <= ST_IDLE;
      end
   end

   assign miso_oe     = (r_state == ST_DATA) && r_rw;
   assign miso        = miso_oe & r_oshift[7];
   assign spi_enabled = r_spi_en;
   assign wr_valid    = r_wr_valid;
   assign wr_addr     = r_wr_addr;
   assign wr_data     = r_wr_data;
   assign core_clk_en = r_cke;

endmodule

// File: tb/tb_adau_spi_responder.sv
// Directed-vector bench for adau_spi_responder: SPI frames
// from a table plus hand-written corner-case sequences.
module tb_adau_spi_responder;

   logic        clk = 1'b0;
   logic        reset;
   logic        sclk;
   logic        cs_n;
   logic        mosi;
   logic        miso;
   logic        miso_oe;
   logic        spi_enabled;
   logic        wr_valid;
   logic [15:0] wr_addr;
   logic [7:0]  wr_data;
   logic        core_clk_en;

   always #5 clk = ~clk;

   adau_spi_responder dut (
      .clk         (clk),
      .reset       (reset),
      .sclk        (sclk),
      .cs_n        (cs_n),
      .mosi        (mosi),
      .miso        (miso),
      .miso_oe     (miso_oe),
      .spi_enabled (spi_enabled),
      .wr_valid    (wr_valid),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .core_clk_en (core_clk_en)
   );

   localparam int H  = 6;
   localparam int NV = 19;

   typedef struct packed {
      logic [39:0] d;
      int          nb;
      int          nstb;
      logic [23:0] s0;
      logic [23:0] s1;
      int          nrd;
      logic [15:0] rd;
      logic        en;
      logic        cke;
   } vec_t;

   vec_t        vt [NV];
   int          n_cmp = 0;
   int          n_bad = 0;
   logic [23:0] stq [$];
   logic [39:0] miso_bits;
   logic [39:0] oe_bits;
   logic [39:0] exp_oe;

   // record every strobe cycle as {addr, data}
   always @(negedge clk)
      if (wr_valid === 1'b1)
         stq.push_back({wr_addr, wr_data});

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, want %0h", nm, act, exp);
      end
   endtask

   task automatic clk_wait(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic bit_x(input logic b, input int idx, input logic cs_last);
      mosi = b;
      clk_wait(H);
      sclk = 1'b1;
      miso_bits[39-idx] = miso;
      oe_bits[39-idx]   = miso_oe;
      if (cs_last)
         cs_n = 1'b1;
      clk_wait(H);
      sclk = 1'b0;
   endtask

   task automatic xfer(input logic [39:0] d, input int nb,
                       input logic cs_last);
      miso_bits = '0;
      oe_bits   = '0;
      stq.delete();
      cs_n = 1'b0;
      clk_wait(H);
      for (int i = 0; i < nb; i++)
         bit_x(d[39-i], i, cs_last && (i == nb - 1));
      clk_wait(H);
      cs_n = 1'b1;
      clk_wait(10);
   endtask

   initial begin
      //          data             nb  ns  s0          s1          nr rd        en    cke
      vt[0]  = '{40'h0040000100, 32, 0, 24'h000000, 24'h000000, 0, 16'h0000, 1'b0, 1'b0};
      vt[1]  = '{40'h0000000000, 32, 0, 24'h000000, 24'h000000, 0, 16'h0000, 1'b0, 1'b0};
      vt[2]  = '{40'h0000000000, 32, 0, 24'h000000, 24'h000000, 0, 16'h0000, 1'b1, 1'b0};
      vt[3]  = '{40'h0000000000, 32, 1, 24'h000000, 24'h000000, 0, 16'h0000, 1'b1, 1'b0};
      vt[4]  = '{40'h0040000100, 32, 1, 24'h400001, 24'h000000, 0, 16'h0000, 1'b1, 1'b1};
      vt[5]  = '{40'h0040F9FF03, 40, 2, 24'h40F9FF, 24'h40FA03, 0, 16'h0000, 1'b1, 1'b1};
      vt[6]  = '{40'h0040164000, 32, 1, 24'h401640, 24'h000000, 0, 16'h0000, 1'b1, 1'b1};
      vt[7]  = '{40'h0140160000, 40, 0, 24'h000000, 24'h000000, 2, 16'h4000, 1'b1, 1'b1};
      vt[8]  = '{40'h0240000000, 32, 0, 24'h000000, 24'h000000, 0, 16'h0000, 1'b1, 1'b1};
      vt[9]  = '{40'h0150000000, 32, 0, 24'h000000, 24'h000000, 1, 16'h0000, 1'b1, 1'b1};
      vt[10] = '{40'h005000AA00, 32, 1, 24'h5000AA, 24'h000000, 0, 16'h0000, 1'b1, 1'b1};
      vt[11] = '{40'h0150000000, 32, 0, 24'h000000, 24'h000000, 1, 16'h0000, 1'b1, 1'b1};
      vt[12] = '{40'h0040000000, 29, 0, 24'h000000, 24'h000000, 0, 16'h0000, 1'b1, 1'b1};
      vt[13] = '{40'h0140000000, 32, 0, 24'h000000, 24'h000000, 1, 16'h0100, 1'b1, 1'b1};
      vt[14] = '{40'h0140F90000, 40, 0, 24'h000000, 24'h000000, 2, 16'hFF03, 1'b1, 1'b1};
      vt[15] = '{40'h00FFFF1122, 40, 2, 24'hFFFF11, 24'h000022, 0, 16'h0000, 1'b1, 1'b1};
      vt[16] = '{40'h0040FF7700, 32, 1, 24'h40FF77, 24'h000000, 0, 16'h0000, 1'b1, 1'b1};
      vt[17] = '{40'h0140FF0000, 40, 0, 24'h000000, 24'h000000, 2, 16'h7700, 1'b1, 1'b1};
      vt[18] = '{40'h0040000000, 32, 1, 24'h400000, 24'h000000, 0, 16'h0000, 1'b1, 1'b0};

      reset = 1'b1;
      sclk  = 1'b0;
      cs_n  = 1'b1;
      mosi  = 1'b0;
      clk_wait(5);
      chk("rst miso", 64'(miso), 64'd0);
      chk("rst miso_oe", 64'(miso_oe), 64'd0);
      chk("rst spi_en", 64'(spi_enabled), 64'd0);
      chk("rst wr_valid", 64'(wr_valid), 64'd0);
      chk("rst wr_addr", 64'(wr_addr), 64'd0);
      chk("rst wr_data", 64'(wr_data), 64'd0);
      chk("rst cke", 64'(core_clk_en), 64'd0);
      reset = 1'b0;
      clk_wait(4);

      for (int i = 0; i < NV; i++) begin
         xfer(vt[i].d, vt[i].nb, 1'b0);
         chk($sformatf("v%0d nstb", i), 64'(stq.size()), 64'(vt[i].nstb));
         for (int k = 0; k < vt[i].nstb && k < stq.size(); k++)
            chk($sformatf("v%0d strobe%0d", i, k), 64'(stq[k]),
                64'((k == 0) ? vt[i].s0 : vt[i].s1));
         for (int k = 0; k < vt[i].nrd; k++)
            chk($sformatf("v%0d rd%0d", i, k),
                64'(miso_bits[15-8*k -: 8]), 64'(vt[i].rd[15-8*k -: 8]));
         exp_oe = '0;
         for (int j = 0; j < 8 * vt[i].nrd; j++)
            exp_oe[15-j] = 1'b1;
         chk($sformatf("v%0d oe_bits", i), 64'(oe_bits), 64'(exp_oe));
         chk($sformatf("v%0d spi_en", i), 64'(spi_enabled), 64'(vt[i].en));
         chk($sformatf("v%0d cke", i), 64'(core_clk_en), 64'(vt[i].cke));
         chk($sformatf("v%0d oe_idle", i), 64'(miso_oe), 64'd0);
      end

      // cs_n rises together with the byte-completing sclk edge
      xfer(40'h0040105A00, 32, 1'b1);
      chk("coinc nstb", 64'(stq.size()), 64'd1);
      if (stq.size() > 0)
         chk("coinc strobe", 64'(stq[0]), 64'h40105A);
      xfer(40'h0140100000, 32, 1'b0);
      chk("coinc readback", 64'(miso_bits[15:8]), 64'h5A);

      // reset in the middle of a frame
      xfer(40'h0040000100, 32, 1'b0);
      chk("pre-rst cke", 64'(core_clk_en), 64'd1);
      miso_bits = '0;
      oe_bits   = '0;
      stq.delete();
      cs_n = 1'b0;
      clk_wait(H);
      for (int i = 0; i < 12; i++)
         bit_x(1'b0, i, 1'b0);
      reset = 1'b1;
      clk_wait(3);
      reset = 1'b0;
      chk("midrst spi_en", 64'(spi_enabled), 64'd0);
      chk("midrst cke", 64'(core_clk_en), 64'd0);
      for (int i = 12; i < 32; i++)
         bit_x(1'b0, i, 1'b0);
      clk_wait(H);
      cs_n = 1'b1;
      clk_wait(10);
      chk("midrst nstb", 64'(stq.size()), 64'd0);
      chk("midrst oe", 64'(oe_bits), 64'd0);
      xfer(40'h0000000000, 32, 1'b0);
      chk("midrst en after 2", 64'(spi_enabled), 64'd0);
      xfer(40'h0000000000, 32, 1'b0);
      chk("midrst en after 3", 64'(spi_enabled), 64'd1);
      xfer(40'h0140000000, 32, 1'b0);
      chk("midrst reg cleared", 64'(miso_bits[15:8]), 64'h00);
      chk("midrst read oe", 64'(oe_bits), 64'h000000FF00);

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
      $finish;
   end

endmodule
